// File: rtl/fetch_sequencer.sv
// Instruction-fetch / PC sequencer: fetches words over req/ready, resolves Bcond/Jcond locally
// against the ALU flags and issues every other instruction to the datapath over valid/done.
module fetch_sequencer #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [15:0]       imem_rdata,
    input  logic [4:0]        flags,
    output logic [3:0]        jreg_sel,
    input  logic [ADDR_W-1:0] jreg_data,
    output logic [15:0]       ex_instr,
    output logic              ex_valid,
    input  logic              ex_done,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [1:0] {StIdle, StFetch, StDecode, StExec} state_e;

    localparam logic [15:0]       NopInstr = 16'h0020;
    localparam logic [ADDR_W-1:0] PcOne    = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;

    logic              is_bcond, is_jcond, cond_taken;
    logic [ADDR_W-1:0] pc_inc, pc_rel;

    // flags layout: bit4 N, bit3 Z, bit2 F, bit1 L, bit0 C
    function automatic logic cond_eval(input logic [3:0] cc, input logic [4:0] f);
        logic z, c, l, n, fl;
        z  = f[3];
        c  = f[0];
        l  = f[1];
        n  = f[4];
        fl = f[2];
        case (cc)
            4'd0:    cond_eval = z;
            4'd1:    cond_eval = !z;
            4'd2:    cond_eval = c;
            4'd3:    cond_eval = !c;
            4'd4:    cond_eval = l;
            4'd5:    cond_eval = !l;
            4'd6:    cond_eval = n;
            4'd7:    cond_eval = !n;
            4'd8:    cond_eval = fl;
            4'd9:    cond_eval = !fl;
            4'd10:   cond_eval = !z && !l;
            4'd11:   cond_eval = z || l;
            4'd12:   cond_eval = !n && !c;
            4'd13:   cond_eval = n || c;
            4'd14:   cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    assign is_bcond   = (ir_q[15:12] == 4'hC);
    assign is_jcond   = (ir_q[15:12] == 4'h4) && (ir_q[7:4] == 4'hC);
    assign cond_taken = cond_eval(ir_q[11:8], flags);
    assign pc_inc     = pc_q + PcOne;
    assign pc_rel     = pc_q + {{(ADDR_W-8){ir_q[7]}}, ir_q[7:0]};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (is_bcond || is_jcond) begin
                    if (!cond_taken) pc_d = pc_inc;
                    else if (is_bcond) pc_d = pc_rel;
                    else pc_d = jreg_data;
                    state_d = run ? StFetch : StIdle;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (ex_done) begin
                    pc_d    = pc_inc;
                    state_d = run ? StFetch : StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ir_q    <= NopInstr;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign imem_req  = (state_q == StFetch);
    assign imem_addr = pc_q;
    assign ex_valid  = (state_q == StExec);
    assign ex_instr  = ir_q;
    assign jreg_sel  = ir_q[3:0];
    assign pc        = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed control-flow programs then randomized programs, with a
// scoreboard fed by an instruction-level reference model and drained by an independent monitor.
module tb_fetch_sequencer;

    localparam logic [15:0] ResetPc = 16'h0000;

    logic        clock, reset, run;
    logic        imem_req, imem_ready;
    logic [15:0] imem_addr, imem_rdata;
    logic [4:0]  flags;
    logic [3:0]  jreg_sel;
    logic [15:0] jreg_data, ex_instr, pc;
    logic        ex_valid, ex_done;

    logic [15:0] mem [65536];
    logic [15:0] regs [16];

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } issue_t;

    issue_t      exp_issue [$];
    logic [15:0] exp_fetch [$];
    logic [15:0] m_pc;

    int checks, failures;
    int im_mode;     // 0 always ready, 1 random ready, 2 never ready
    bit dp_hold;     // datapath completes only when released via dp_go
    int dp_go, dp_used, dp_wait;
    bit rand_flags;

    assign jreg_data = regs[jreg_sel];

    fetch_sequencer #(
        .ADDR_W   (16),
        .RESET_PC (ResetPc)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .flags      (flags),
        .jreg_sel   (jreg_sel),
        .jreg_data  (jreg_data),
        .ex_instr   (ex_instr),
        .ex_valid   (ex_valid),
        .ex_done    (ex_done),
        .pc         (pc)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit tb_cond(input logic [3:0] cc, input logic [4:0] f);
        bit z, c, l, n, ff;
        bit tab [16];
        z  = f[3];
        c  = f[0];
        l  = f[1];
        n  = f[4];
        ff = f[2];
        tab = '{z, !z, c, !c, l, !l, n, !n, ff, !ff, !z && !l, z || l, !n && !c, n || c,
                1'b1, 1'b0};
        return tab[cc];
    endfunction

    // One architectural step of the program at m_pc, using the flags/registers visible now.
    task automatic model_step(input logic [15:0] w);
        int d;
        if (w[15:12] == 4'hC) begin
            d = int'(w[7:0]);
            if (d >= 128) d -= 256;
            if (tb_cond(w[11:8], flags)) m_pc = 16'((int'(m_pc) + d) & 32'hFFFF);
            else m_pc = 16'((int'(m_pc) + 1) & 32'hFFFF);
        end else if (w[15:12] == 4'h4 && w[7:4] == 4'hC) begin
            if (tb_cond(w[11:8], flags)) m_pc = regs[w[3:0]];
            else m_pc = 16'((int'(m_pc) + 1) & 32'hFFFF);
        end else begin
            exp_issue.push_back('{instr: w, pc: m_pc});
            m_pc = 16'((int'(m_pc) + 1) & 32'hFFFF);
        end
        exp_fetch.push_back(m_pc);
    endtask

    // Instruction memory responder; also the point where stimulus enters the model.
    initial begin
        imem_ready = 1'b0;
        imem_rdata = 16'h0000;
        forever begin
            @(negedge clock);
            imem_ready = 1'b0;
            imem_rdata = 16'($urandom);
            if (reset) begin
                exp_fetch.delete();
                exp_issue.delete();
                m_pc = ResetPc;
                exp_fetch.push_back(m_pc);
            end else if (imem_req && (im_mode == 0 || (im_mode == 1 && $urandom_range(0, 2) == 0)))
            begin
                imem_ready = 1'b1;
                imem_rdata = mem[imem_addr];
                model_step(mem[m_pc]);
            end
        end
    end

    // Datapath responder: completes issued instructions and then updates flags/registers.
    initial begin
        ex_done = 1'b0;
        dp_wait = 0;
        dp_used = 0;
        forever begin
            @(negedge clock);
            if (ex_done || reset) begin
                ex_done = 1'b0;
            end else if (ex_valid) begin
                if (dp_hold) begin
                    if (dp_go > dp_used) begin
                        dp_used++;
                        ex_done = 1'b1;
                    end
                end else if (dp_wait == 0) begin
                    ex_done = 1'b1;
                    dp_wait = $urandom_range(0, 3);
                    if (rand_flags) begin
                        flags = 5'($urandom);
                        foreach (regs[i]) regs[i] = 16'($urandom);
                    end
                end else begin
                    dp_wait--;
                end
            end
        end
    end

    // Monitor: compares every completed fetch and every completed issue with the scoreboard.
    initial begin
        issue_t e;
        forever begin
            @(negedge clock);
            #4;
            if (!reset) begin
                if (imem_req && imem_ready) begin
                    if (exp_fetch.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL fetch_unexpected addr=%h required=none", imem_addr);
                    end else begin
                        check("fetch_addr", 32'(imem_addr), 32'(exp_fetch.pop_front()));
                    end
                end
                if (ex_valid && ex_done) begin
                    if (exp_issue.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL issue_unexpected instr=%h pc=%h required=none",
                                 ex_instr, pc);
                    end else begin
                        e = exp_issue.pop_front();
                        check("issue_instr", 32'(ex_instr), 32'(e.instr));
                        check("issue_pc", 32'(pc), 32'(e.pc));
                    end
                end
            end
        end
    end

    task automatic wait_ex(input string name, output int n);
        int guard;
        guard = 0;
        while (ex_valid && guard < 20) begin
            @(posedge clock);
            #1;
            guard++;
        end
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!ex_valid && n < 60);
        if (!ex_valid) begin
            checks++;
            failures++;
            $display("FAIL %s ex_valid=0 required=1 within %0d cycles", name, n);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog sim_time=%0t required=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, quiet, g, rst_left;
        logic [15:0] w;
        int r;
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        run        = 1'b0;
        im_mode    = 0;
        dp_hold    = 1'b1;
        dp_go      = 0;
        rand_flags = 1'b0;
        flags      = 5'b01000;
        foreach (regs[i]) regs[i] = 16'h0F00 + 16'(i);
        regs[7] = 16'h0100;
        regs[8] = 16'hFFFF;
        regs[9] = 16'hFFF0;
        foreach (mem[i]) mem[i] = 16'h0000;
        mem[16'h0000] = 16'h1234;
        mem[16'h0001] = 16'hCE04;
        mem[16'h0005] = 16'hC0FE;
        mem[16'h0003] = 16'h4EC7;
        mem[16'h0100] = 16'h4FC7;
        mem[16'h0101] = 16'hC1FE;
        mem[16'h0102] = 16'h0000;
        mem[16'h0103] = 16'h4EC8;
        mem[16'hFFFF] = 16'h5555;
        mem[16'hFFF0] = 16'hCE7F;
        mem[16'h006F] = 16'h6666;

        repeat (3) @(posedge clock);
        #1;
        check("reset_imem_req", 32'(imem_req), 32'd0);
        check("reset_ex_valid", 32'(ex_valid), 32'd0);
        check("reset_pc", 32'(pc), 32'(ResetPc));
        check("reset_ex_instr", 32'(ex_instr), 32'h0020);
        check("reset_jreg_sel", 32'(jreg_sel), 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("idle_no_req", 32'(imem_req), 32'd0);

        run = 1'b1;
        wait_ex("first_issue", n);
        check("alu_latency", 32'(n), 32'd3);
        check("first_pc", 32'(pc), 32'h0000);
        check("first_instr", 32'(ex_instr), 32'h1234);
        check("first_jreg_sel", 32'(jreg_sel), 32'd4);

        dp_go++;
        wait_ex("branch_chain", n);
        check("branch_chain_pc", 32'(pc), 32'h0102);
        check("branch_chain_instr", 32'(ex_instr), 32'h0000);

        mem[16'h0000] = 16'h4EC9;
        dp_go++;
        wait_ex("jump_top", n);
        check("jump_top_pc", 32'(pc), 32'hFFFF);
        check("jump_top_instr", 32'(ex_instr), 32'h5555);

        dp_go++;
        wait_ex("wrap", n);
        check("wrap_bcond_pc", 32'(pc), 32'h006F);
        check("wrap_bcond_instr", 32'(ex_instr), 32'h6666);

        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check("exec_stall_valid", 32'(ex_valid), 32'd1);
            check("exec_stall_instr", 32'(ex_instr), 32'h6666);
            check("exec_stall_pc", 32'(pc), 32'h006F);
        end

        reset = 1'b1;
        run   = 1'b0;
        @(posedge clock);
        #1;
        check("exec_reset_valid", 32'(ex_valid), 32'd0);
        check("exec_reset_pc", 32'(pc), 32'(ResetPc));
        check("exec_reset_req", 32'(imem_req), 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("exec_reset_idle", 32'(imem_req), 32'd0);

        mem[16'h0000] = 16'h7777;
        run = 1'b1;
        wait_ex("run_drop_issue", n);
        check("run_drop_instr", 32'(ex_instr), 32'h7777);
        run = 1'b0;
        dp_go++;
        repeat (4) @(posedge clock);
        #1;
        check("run_drop_pc", 32'(pc), 32'h0001);
        check("run_drop_req", 32'(imem_req), 32'd0);
        check("run_drop_valid", 32'(ex_valid), 32'd0);

        im_mode = 2;
        mem[16'h0001] = 16'h8888;
        run = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            check("fetch_stall_req", 32'(imem_req), 32'd1);
            check("fetch_stall_addr", 32'(imem_addr), 32'h0001);
            @(posedge clock);
            #1;
        end
        im_mode = 0;
        wait_ex("fetch_resume", n);
        check("fetch_resume_pc", 32'(pc), 32'h0001);

        run     = 1'b0;
        dp_hold = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        foreach (mem[i]) begin
            r = $urandom_range(0, 9);
            w = 16'($urandom);
            if (r < 3) begin
                w[15:12] = 4'hC;
            end else if (r < 6) begin
                w[15:12] = 4'h4;
                w[7:4]   = 4'hC;
            end
            mem[i] = w;
        end
        foreach (regs[i]) regs[i] = 16'($urandom);
        rand_flags = 1'b1;
        im_mode    = 1;
        run        = 1'b1;
        rst_left   = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clock);
            #1;
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) reset = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                reset    = 1'b1;
                rst_left = 2;
            end
            if (run) begin
                if ($urandom_range(0, 39) == 0) run = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                run = 1'b1;
            end
        end

        reset = 1'b0;
        run   = 1'b0;
        quiet = 0;
        g     = 0;
        while (quiet < 2 && g < 300) begin
            @(posedge clock);
            #1;
            g++;
            quiet = (!imem_req && !ex_valid) ? quiet + 1 : 0;
        end
        check("drain_idle", 32'(quiet >= 2), 32'd1);
        check("drain_issue_empty", 32'(exp_issue.size()), 32'd0);
        check("drain_fetch_pending", 32'(exp_fetch.size()), 32'd1);
        if (exp_fetch.size() > 0) check("drain_park_pc", 32'(pc), 32'(exp_fetch[0]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
